// File: rtl/tick_divider.sv
// tick_divider: single-clock timebase producing one-cycle enable pulses
// (base tick, 1 Hz tick, slow/fast time-set repeat tick), the seconds phase,
// and a 50 % blink level. No derived clocks; everything qualifies on clk.
module tick_divider #(
    parameter int unsigned CLK_HZ       = 12500,
    parameter int unsigned BASE_HZ      = 10,
    parameter int unsigned SET_SLOW_DIV = 5,
    parameter int unsigned SET_FAST_DIV = 2,
    localparam int unsigned PRE = CLK_HZ / BASE_HZ,
    localparam int unsigned PW  = (PRE > 1) ? $clog2(PRE) : 1,
    localparam int unsigned SW  = (BASE_HZ > 1) ? $clog2(BASE_HZ) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic          sync,
    input  logic          fast_set,
    output logic          tick_base,
    output logic          tick_1hz,
    output logic          tick_set,
    output logic          blink,
    output logic [SW-1:0] phase
);

    // Terminal values, all at counter width so every compare is unsigned.
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRE - 1);
    localparam logic [SW-1:0] PHASE_LAST = SW'(BASE_HZ - 1);
    localparam logic [SW-1:0] BLINK_HALF = SW'(BASE_HZ / 2);
    localparam logic [SW-1:0] SLOW_LAST  = SW'(SET_SLOW_DIV - 1);
    localparam logic [SW-1:0] FAST_LAST  = SW'(SET_FAST_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] phase_q, phase_d;
    logic [SW-1:0] setc_q, setc_d;
    logic          fast_q, fast_d;
    logic          tick_base_q, tick_base_d;
    logic          tick_1hz_q, tick_1hz_d;
    logic          tick_set_q, tick_set_d;
    logic          blink_q, blink_d;

    logic          pre_wrap;
    logic          phase_wrap;
    logic          setc_wrap;
    logic          mode_chg;
    logic [SW-1:0] setc_last;

    // Next-state: sync restart, freeze, prescale/phase/set counting, mode change.
    always_comb begin
        pre_d       = pre_q;
        phase_d     = phase_q;
        setc_d      = setc_q;
        fast_d      = fast_set;
        tick_base_d = 1'b0;
        tick_1hz_d  = 1'b0;
        tick_set_d  = 1'b0;

        setc_last  = fast_set ? FAST_LAST : SLOW_LAST;
        pre_wrap   = (pre_q == PRE_LAST);
        phase_wrap = (phase_q == PHASE_LAST);
        setc_wrap  = (setc_q == setc_last);
        mode_chg   = (fast_set != fast_q);

        if (sync) begin
            pre_d   = '0;
            phase_d = '0;
            setc_d  = '0;
        end else begin
            if (ena) begin
                if (pre_wrap) begin
                    pre_d       = '0;
                    tick_base_d = 1'b1;
                    phase_d     = phase_wrap ? '0 : phase_q + SW'(1);
                    tick_1hz_d  = phase_wrap;
                    setc_d      = setc_wrap ? '0 : setc_q + SW'(1);
                    tick_set_d  = setc_wrap;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            // A rate switch restarts the set cadence, even while frozen.
            if (mode_chg) begin
                setc_d     = '0;
                tick_set_d = 1'b0;
            end
        end

        // Blink follows the phase the register will hold next cycle.
        blink_d = (phase_d < BLINK_HALF);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            phase_q     <= '0;
            setc_q      <= '0;
            fast_q      <= fast_set;
            tick_base_q <= 1'b0;
            tick_1hz_q  <= 1'b0;
            tick_set_q  <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            setc_q      <= setc_d;
            fast_q      <= fast_d;
            tick_base_q <= tick_base_d;
            tick_1hz_q  <= tick_1hz_d;
            tick_set_q  <= tick_set_d;
            blink_q     <= blink_d;
        end
    end

    assign tick_base = tick_base_q;
    assign tick_1hz  = tick_1hz_q;
    assign tick_set  = tick_set_q;
    assign blink     = blink_q;
    assign phase     = phase_q;

endmodule

// File: doc/tick_divider.md
# tick_divider

Parametrised single-clock timebase for the digital clock. It divides the system clock into one-cycle enable pulses: a base tick, a 1 Hz tick, and a time-set repeat tick with selectable slow/fast rate. It also produces a 50 % blink level for the display. All downstream counters and the time-set FSM run on `clk` and qualify on these pulses; no derived clocks exist.

## Interface

**Parameters**
- `CLK_HZ`, 12500: input clock frequency. Must be an integer multiple of `BASE_HZ`.
- `BASE_HZ`, 10: base tick rate. Must be even and ≥ 2.
- `SET_SLOW_DIV`, 5: base ticks per `tick_set` in slow mode (2 Hz at defaults). Range 1..`BASE_HZ`.
- `SET_FAST_DIV`, 2: base ticks per `tick_set` in fast mode (5 Hz at defaults). Range 1..`BASE_HZ`.
- Derived, not overridable: `PRE = CLK_HZ/BASE_HZ`, `PW = $clog2(PRE)`, `SW = $clog2(BASE_HZ)`.

**Ports**
- `clk` input 1: system clock, rising edge only.
- `reset` input 1: reset, synchronous, active-high.
- `ena` input 1: count enable. Low freezes all counters.
- `sync` input 1: soft restart of the second phase, used by the time-set FSM on exit.
- `fast_set` input 1: selects `SET_FAST_DIV` when 1, `SET_SLOW_DIV` when 0.
- `tick_base` output 1: one-cycle pulse at `BASE_HZ`.
- `tick_1hz` output 1: one-cycle pulse once per second.
- `tick_set` output 1: one-cycle set-repeat pulse.
- `blink` output 1: 1 Hz square wave, high during the first half of each second.
- `phase` output SW: base ticks elapsed in the current second, 0..`BASE_HZ-1`.

## Operation

- **Registers:**
  - `pre` (PW bits, 0..PRE-1)
  - `phase` (SW bits)
  - `setc` (SW bits, 0..DIV-1)
  - `fast_q` (last sampled `fast_set`)
  - the three tick flops
- **Priority per edge:** `reset` > `sync` > `ena` = 0 > count.
- **Reset:** all counters 0, `fast_q` ← `fast_set`, ticks 0.
- **Sync:** `pre`, `phase`, `setc` ← 0; ticks ← 0. `fast_q` still tracks `fast_set`.
- **`ena` = 0:** counters hold. Tick flops load 0, so no pulse is ever stretched or repeated.
- **Count (`ena` = 1):**
  - If `pre == PRE-1`: `pre` ← 0 and `tick_base` ← 1. Otherwise `pre` ← `pre`+1 and `tick_base` ← 0.
  - On a `pre` wrap: `phase` wraps `BASE_HZ-1` → 0, else increments. `tick_1hz` ← 1 iff `phase == BASE_HZ-1`.
  - On a `pre` wrap: `setc` wraps `DIV-1` → 0, else increments. `tick_set` ← 1 iff `setc == DIV-1`, where `DIV` is chosen by the current `fast_set`.
- **Mode change:** on any edge where `fast_set != fast_q` (and no reset or sync), `setc` ← 0 and `tick_set` ← 0 regardless of a coincident wrap. `fast_q` ← `fast_set` every edge.
- **Blink:** `blink = (phase < BASE_HZ/2)`, combinational from the `phase` register.
- **Arithmetic:** all compares are unsigned at counter width. No counter ever exceeds its terminal value. `DIV` = 1 yields `tick_set` on every `tick_base`.
- **Coincidence:** `tick_1hz` and `tick_set` (when aligned) always coincide with `tick_base`.

## Timing

- **Cycle numbering:** cycle 0 is the first cycle with `reset` = 0 (or `sync` = 0 after a sync).
- **`tick_base`:** first high in cycle `PRE`, then every `PRE` enabled cycles.
- **`tick_1hz`:** first high in cycle `PRE*BASE_HZ`. Period `PRE*BASE_HZ` enabled cycles.
- **`tick_set`:** first high in cycle `PRE*DIV` after reset, sync or mode change.
- **Ticks:** registered outputs, exactly 1 cycle wide.
- **`blink`, `phase`:** change in the same cycle `tick_base` rises.
- **Freeze:** `ena` low for k cycles delays every subsequent tick by exactly k cycles.
- **Reset values:** `tick_base` = `tick_1hz` = `tick_set` = 0, `phase` = 0, `blink` = 1.

## Test plan

- **Reset and free run (defaults):** release `reset`, hold `ena` = 1 for 30000 cycles.
  - Required: `tick_base` in cycles 1250, 2500, …
  - Required: `tick_1hz` only at 12500 and 25000.
  - Required: `blink` = 1 during cycles 0–6249, 0 during 6250–12499.
- **Set rates:**
  - `fast_set` = 0: `tick_set` at cycles 6250, 12500, ….
  - Toggle `fast_set` to 1 at cycle 7000: no `tick_set` that cycle; next `tick_set` at cycle 7500 + 1250 = 8750 (two base ticks after the mode-change edge), then every 2500 cycles.
- **Enable freeze:** drop `ena` for cycles 1000–1099.
  - Required: first `tick_base` at cycle 1350, `tick_1hz` at 12600, no ticks while `ena` = 0.
- **Sync mid-second:**
  - Pulse `sync` in cycle 9000 (`phase` = 7): `phase` = 0 and ticks 0 in the following cycle.
  - Next `tick_1hz` 12500 cycles after the sync deasserts.
- **Reset mid-operation and priority:**
  - Assert `reset` together with `sync` on a `tick_1hz` terminal cycle: all outputs hold reset values next cycle, `blink` = 1, no pulse emitted.
- **Parameter sweep:** `CLK_HZ` = 100, `BASE_HZ` = 4, `SET_SLOW_DIV` = 1, `SET_FAST_DIV` = 4.
  - Required: `tick_base` every 25 cycles, `tick_1hz` every 100.
  - Required: `tick_set` every 25 (slow mode) and every 100 (fast mode).
